window_mem_ctrl: RTL and testbench

WINDOW_MEM_CTRL -- requirements
Module: window_mem_ctrl

---
 rtl/window_pkg.sv | 26 ++
 rtl/window_mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_window_mem_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_pkg.sv
// Shared constants and FSM state type for the window memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package window_pkg;

  // Default frame geometry: 256x32 output windows, one pixel of padding on each side
  localparam int DEF_IMG_W  = 256;
  localparam int DEF_IMG_H  = 32;
  localparam int DEF_PAD_W  = DEF_IMG_W + 2;
  localparam int DEF_LOAD_N = DEF_PAD_W * (DEF_IMG_H + 2);

  // Counter and index widths
  localparam int ROW_W = 5;
  localparam int COL_W = 8;
  localparam int CNT_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_SCAN,
    ST_FLUSH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/window_mem_ctrl.sv
// Frame sequencer for the 3x3 window memory: clear pointers, load padded frame, scan windows.
// Latency: write path combinational; win_valid/win_row/win_col one cycle after each mem_rd.
// Backpressure: in_valid gaps hold the load count; out_ready low holds the scan position.
module window_mem_ctrl
  import window_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int PAD_W  = IMG_W + 2,
  parameter int LOAD_N = PAD_W * (IMG_H + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [7:0]       pixel_in,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             mem_rst_n,
  output logic             mem_wr,
  output logic [7:0]       mem_pixelw,
  output logic             mem_rd,
  output logic             win_valid,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic             mem_rst_n_q;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             win_valid_q;
  logic [ROW_W-1:0] win_row_q;
  logic [COL_W-1:0] win_col_q;

  logic in_load, in_scan;
  logic load_last, col_last, row_last, scan_last;

  assign in_load   = (state_q == ST_LOAD);
  assign in_scan   = (state_q == ST_SCAN);
  assign load_last = in_load && in_valid && (load_cnt_q == CNT_W'(LOAD_N - 1));
  assign col_last  = (col_q == COL_W'(IMG_W - 1));
  assign row_last  = (row_q == ROW_W'(IMG_H - 1));
  assign scan_last = mem_rd && col_last && row_last;

  // Pixel path is a straight wire during LOAD; forced quiet otherwise
  assign in_ready   = in_load;
  assign mem_wr     = in_load && in_valid;
  assign mem_pixelw = in_load ? pixel_in : 8'h00;
  assign mem_rd     = in_scan && out_ready;

  assign mem_rst_n = mem_rst_n_q;
  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  // Frame sequencer; mem_rst_n is registered so it is low exactly during CLR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_rst_n_q <= 1'b0;
    end else begin
      mem_rst_n_q <= 1'b1;
      if (abort) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q     <= ST_CLR;
              mem_rst_n_q <= 1'b0;
            end
          end
          ST_CLR:   state_q <= ST_LOAD;
          ST_LOAD:  if (load_last) state_q <= ST_SCAN;
          ST_SCAN:  if (scan_last) state_q <= ST_FLUSH;
          ST_FLUSH: state_q <= ST_DONE;
          ST_DONE:  state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Next values for load count and scan position; cleared on CLR or abort
  always_comb begin
    load_cnt_d = load_cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    if (abort || (state_q == ST_CLR)) begin
      load_cnt_d = '0;
      row_d      = '0;
      col_d      = '0;
    end else begin
      if (mem_wr) begin
        load_cnt_d = load_cnt_q + CNT_W'(1);
      end
      if (mem_rd) begin
        if (col_last) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      load_cnt_q <= load_cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
    end
  end

  // Window qualifier tracks the memory's one-cycle read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      win_valid_q <= mem_rd;
      if (mem_rd) begin
        win_row_q <= row_q;
        win_col_q <= col_q;
      end
    end
  end

endmodule

// File: tb/tb_window_mem_ctrl.sv
// Self-checking bench for window_mem_ctrl with a frame-level reference model.
module tb_window_mem_ctrl;

  localparam int IMG_W  = 256;
  localparam int IMG_H  = 32;
  localparam int LOAD_N = (IMG_W + 2) * (IMG_H + 2);
  localparam int NWIN   = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, in_valid, out_ready;
  logic [7:0] pixel_in;
  logic       in_ready, mem_rst_n, mem_wr, mem_rd, win_valid, busy, done;
  logic [7:0] mem_pixelw;
  logic [4:0] win_row;
  logic [7:0] win_col;

  int vectors = 0;
  int miscompares = 0;
  // Frame-level observation counters, zeroed by the stimulus before each frame
  int nwr, nrd, nwin, ndone, nclr;
  logic prev_rd;

  window_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .pixel_in(pixel_in), .in_ready(in_ready),
    .out_ready(out_ready), .mem_rst_n(mem_rst_n), .mem_wr(mem_wr),
    .mem_pixelw(mem_pixelw), .mem_rd(mem_rd), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    nwr = 0; nrd = 0; nwin = 0; ndone = 0; nclr = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_pixelw"}, mem_pixelw, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_win_row"}, win_row, 0);
    chk({tag, "_win_col"}, win_col, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mem_rst_n"}, mem_rst_n, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Windows must appear in raster order, exactly one cycle after their strobe
  initial begin
    clr_counts();
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("win_valid_follows_rd", win_valid, prev_rd);
        chk("mem_wr_gate", mem_wr, in_ready & in_valid);
        if (mem_wr) chk("pixel_pass", mem_pixelw, pixel_in);
        if (win_valid) begin
          chk("win_row_order", win_row, nwin / IMG_W);
          chk("win_col_order", win_col, nwin % IMG_W);
          nwin++;
        end
        nwr   += int'(mem_wr);
        nrd   += int'(mem_rd);
        ndone += int'(done);
        if (!mem_rst_n) nclr++;
        prev_rd = mem_rd;
      end else begin
        prev_rd = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    chk("start_idle_busy", busy, 0);
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    chk("clr_mem_rst_n", mem_rst_n, 0);
    chk("clr_busy", busy, 1);
    chk("clr_in_ready", in_ready, 0);
    next_cycle();
  endtask

  task automatic do_load(input int pct, input bit poke_start);
    int acc = 0;
    int cyc = 0;
    while (acc < LOAD_N && cyc < 4 * LOAD_N) begin
      in_valid = ($urandom_range(99) < pct);
      pixel_in = 8'($urandom_range(255));
      start    = poke_start && (acc == 100);
      @(negedge clk);
      chk("load_in_ready", in_ready, 1);
      if (in_valid) acc++;
      cyc++;
      next_cycle();
    end
    start = 1'b0;
    chk("load_accepted", acc, LOAD_N);
  endtask

  // mode 0: stall 10 cycles before window (3,255); mode 1: random out_ready
  task automatic do_scan(input int mode, input int abort_at, input bit poke_start);
    int ns = 0;
    int cyc = 0;
    int stall = 0;
    while (ns < NWIN && cyc < 40000) begin
      if (mode == 0) begin
        if (ns == 3 * IMG_W + IMG_W - 1 && stall < 10) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready = ($urandom_range(3) != 0);
      end
      in_valid = 1'($urandom_range(1));
      pixel_in = 8'($urandom_range(255));
      start    = poke_start && (ns == 50);
      abort    = (abort_at >= 0) && (ns == abort_at) && out_ready;
      @(negedge clk);
      chk("scan_mem_rd", mem_rd, out_ready);
      chk("scan_in_ready", in_ready, 0);
      chk("scan_busy", busy, 1);
      if (abort) begin
        next_cycle();
        abort = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_mem_rd", mem_rd, 0);
        chk("abort_last_win", win_valid, 1);
        chk("abort_win_row", win_row, abort_at / IMG_W);
        next_cycle();
        @(negedge clk);
        chk("abort_no_more_win", win_valid, 0);
        chk("abort_no_done", ndone, 0);
        next_cycle();
        return;
      end
      if (out_ready) ns++;
      cyc++;
      next_cycle();
    end
    start = 1'b0;
    out_ready = 1'($urandom_range(1));
    chk("scan_strobes", ns, NWIN);
    @(negedge clk);
    chk("flush_mem_rd", mem_rd, 0);
    chk("flush_win_valid", win_valid, 1);
    chk("flush_done", done, 0);
    chk("flush_busy", busy, 1);
    next_cycle();
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_win_valid", win_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    next_cycle();
  endtask

  task automatic frame_totals(input string tag);
    chk({tag, "_writes"}, nwr, LOAD_N);
    chk({tag, "_reads"}, nrd, NWIN);
    chk({tag, "_windows"}, nwin, NWIN);
    chk({tag, "_done_count"}, ndone, 1);
    chk({tag, "_clear_count"}, nclr, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pixel_in = 8'h00;
    #2;
    chk_reset_outputs("por");
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_mem_rst_n_low", mem_rst_n, 0);
    next_cycle();
    @(negedge clk);
    chk("rst_release_mem_rst_n_high", mem_rst_n, 1);
    chk("rst_release_busy", busy, 0);
    next_cycle();

    // Frame 1: back-to-back pixels, stall at (3,255), stray start pulses
    clr_counts();
    do_start();
    do_load(100, 1'b1);
    do_scan(0, -1, 1'b1);
    frame_totals("f1");

    // Asynchronous reset in the middle of LOAD
    clr_counts();
    do_start();
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      pixel_in = 8'hA5;
      next_cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midload");
    in_valid = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midload_release_mem_rst_n", mem_rst_n, 0);
    next_cycle();
    @(negedge clk);
    chk("midload_idle", busy, 0);
    next_cycle();

    // Frame 2: 50% input gaps, aborted in SCAN at row 10
    clr_counts();
    do_start();
    do_load(50, 1'b0);
    do_scan(1, 10 * IMG_W + 7, 1'b0);
    chk("f2_writes", nwr, LOAD_N);
    chk("f2_done_count", ndone, 0);

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("startabort_busy_now", busy, 0);
    next_cycle();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("startabort_busy_next", busy, 0);
    chk("startabort_no_clr", mem_rst_n, 1);
    next_cycle();

    // Frame 3: full frame after abort, random out_ready
    clr_counts();
    do_start();
    do_load(100, 1'b0);
    do_scan(1, -1, 1'b0);
    frame_totals("f3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
